// File: rtl/sram_init_pkg.sv
// Shared types for the single-port SRAM initiator: FSM state and request bundle.
// The request struct is sized by the package default widths.
package sram_init_pkg;

  localparam int PKG_DATA_WIDTH = 8;
  localparam int PKG_DEPTH      = 32;
  localparam int PKG_ADDR_WIDTH = $clog2(PKG_DEPTH);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic                      write;
    logic [PKG_ADDR_WIDTH-1:0] addr;
    logic [PKG_DATA_WIDTH-1:0] wdata;
    logic [PKG_DATA_WIDTH-1:0] wmask;
  } req_t;

endpackage

// File: rtl/sram_1rw_initiator_rsp_fifo2.sv
// Two-entry in-order response FIFO with occupancy count; head is read straight
// from the storage registers so the output is glitch-free once an entry lands.
module rsp_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [1:0]       o_count,
  output logic             o_empty
);

  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [WIDTH-1:0] r_entry;
    always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
        r_entry <= '0;
      end else if (w_push && (r_wptr == 1'(gi))) begin
        r_entry <= i_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_rptr ? g_entry[1].r_entry : g_entry[0].r_entry;
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/sram_1rw_initiator.sv
// Requester-side controller for a 1rw bit-masked SRAM: optional post-reset clear,
// zero-latency request-to-port mapping, and credit-limited read response path.
module sram_1rw_initiator
  import sram_init_pkg::*;
#(
  parameter int                    DATA_WIDTH     = PKG_DATA_WIDTH,
  parameter int                    DEPTH          = PKG_DEPTH,
  parameter int                    ADDR_WIDTH     = $clog2(DEPTH),
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  a_re,
  output logic                  a_we,
  output logic [ADDR_WIDTH-1:0] a_addr,
  output logic [DATA_WIDTH-1:0] a_data_in,
  output logic [DATA_WIDTH-1:0] a_wmask,
  input  logic [DATA_WIDTH-1:0] a_data_out
);

  localparam state_e RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_busy;
  logic                  r_inflight;

  req_t                  w_req;
  logic                  w_clearing;
  logic                  w_run;
  logic                  w_credit_ok;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_empty;
  logic [1:0]            w_fifo_count;
  logic [DATA_WIDTH-1:0] w_fifo_data;

  assign w_req = {req_write, req_addr, req_wdata, req_wmask};

  // Port activity is qualified by rst_b so the SRAM sees an idle port while reset is held.
  assign w_clearing  = rst_b && (r_state == CLEAR);
  assign w_run       = rst_b && (r_state == RUN);
  assign w_credit_ok = ({1'b0, r_inflight} + w_fifo_count) < 2'd2;
  assign req_ready   = w_run && w_credit_ok;
  assign w_accept    = req_valid && req_ready;
  assign busy        = r_busy;

  always_comb begin
    a_re      = 1'b0;
    a_we      = 1'b0;
    a_addr    = '0;
    a_data_in = '0;
    a_wmask   = '0;
    if (w_clearing) begin
      a_we      = 1'b1;
      a_addr    = r_cnt;
      a_data_in = CLEAR_VALUE;
      a_wmask   = '1;
    end else if (w_accept) begin
      a_addr = w_req.addr;
      if (w_req.write) begin
        a_we      = 1'b1;
        a_data_in = w_req.wdata;
        a_wmask   = w_req.wmask;
      end else begin
        a_re = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= RESET_STATE;
      r_cnt      <= '0;
      r_busy     <= CLEAR_ON_RESET;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_accept && !w_req.write;
      case (r_state)
        CLEAR: begin
          if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  // Fresh read data bypasses the FIFO only when nothing older is queued and the consumer takes it.
  assign w_push = r_inflight && (!w_fifo_empty || !rsp_ready);
  assign w_pop  = !w_fifo_empty && rsp_ready;

  rsp_fifo2 #(
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (a_data_out),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  assign rsp_valid = !w_fifo_empty || r_inflight;
  assign rsp_rdata = !w_fifo_empty ? w_fifo_data :
                     (r_inflight ? a_data_out : '0);

endmodule

// File: tb/tb_sram_1rw_initiator.sv
// Directed and randomized bench for sram_1rw_initiator with a behavioural SRAM
// and a transaction-level reference memory plus expected-response queue.
module tb_sram_1rw_initiator;

  localparam int         DW    = 8;
  localparam int         DEPTH = 32;
  localparam int         AW    = 5;
  localparam logic [7:0] CLR   = 8'hA5;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          a_re;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data_in;
  logic [DW-1:0] a_wmask;
  logic [DW-1:0] a_data_out;

  sram_1rw_initiator #(
    .DATA_WIDTH     (DW),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (1'b1),
    .CLEAR_VALUE    (CLR)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wmask  (req_wmask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .busy       (busy),
    .a_re       (a_re),
    .a_we       (a_we),
    .a_addr     (a_addr),
    .a_data_in  (a_data_in),
    .a_wmask    (a_wmask),
    .a_data_out (a_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: bit-masked write, registered read, undefined read-during-write.
  logic [DW-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (a_we) sram[a_addr] <= (sram[a_addr] & ~a_wmask) | (a_data_in & a_wmask);
    if (a_re) a_data_out <= a_we ? 'x : sram[a_addr];
  end

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];
  int            acc_q [$];
  int            addr_q [$];
  int            wr_seen [DEPTH];
  int  errors = 0, checks = 0, cyc = 0;
  int  clr_idx = 0, clr_ok = 0, overlap = 0, re3 = 0, n_rsp = 0;
  bit  acc_flag = 1'b0, chk_lat = 1'b0;
  logic [DW-1:0] last_rsp = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: sample at negedge, update the reference model, return at posedge+1.
  task automatic cycle();
    logic [DW-1:0] e;
    int a;
    int ad;
    @(negedge clk);
    acc_flag = 1'b0;
    if (a_re && a_we) overlap++;
    if (a_re && a_addr == AW'(3)) re3++;
    if (busy) begin
      if (a_we && !a_re && a_wmask == 8'hFF && a_data_in == CLR &&
          a_addr == AW'(clr_idx) && !req_ready && !rsp_valid) clr_ok++;
      if (a_we) wr_seen[a_addr]++;
      clr_idx++;
    end
    if (rsp_valid && rsp_ready) begin
      check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        a  = acc_q.pop_front();
        ad = addr_q.pop_front();
        $display("rsp  #%0d addr=%0d data=%h exp=%h", n_rsp, ad, rsp_rdata, e);
        check("rsp_data", 32'(rsp_rdata), 32'(e));
        if (chk_lat) check("rsp_latency", cyc - a, 32'd1);
        last_rsp = rsp_rdata;
        n_rsp++;
      end
    end
    if (req_valid && req_ready) begin
      acc_flag = 1'b1;
      if (req_write) begin
        ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
        $display("wr   addr=%0d data=%h mask=%h", req_addr, req_wdata, req_wmask);
      end else begin
        exp_q.push_back(ref_mem[req_addr]);
        acc_q.push_back(cyc);
        addr_q.push_back(int'(req_addr));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input bit wr, input int addr, input logic [7:0] d,
                       input logic [7:0] m, output int tries);
    tries = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = AW'(addr);
    req_wdata = d;
    req_wmask = m;
    do begin
      cycle();
      tries++;
    end while (!acc_flag && tries < 50);
    check("issue_accept", 32'(acc_flag), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 100) begin
      cycle();
      n++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, "_a_re"}, 32'(a_re), 32'd0);
    check({tag, "_a_we"}, 32'(a_we), 32'd0);
    check({tag, "_a_addr"}, 32'(a_addr), 32'd0);
    check({tag, "_a_data_in"}, 32'(a_data_in), 32'd0);
    check({tag, "_a_wmask"}, 32'(a_wmask), 32'd0);
  endtask

  task automatic start_clear_tracking();
    clr_idx = 0;
    clr_ok  = 0;
    foreach (wr_seen[i]) wr_seen[i] = 0;
    exp_q.delete();
    acc_q.delete();
    addr_q.delete();
  endtask

  task automatic finish_clear(input string tag);
    int n = 0;
    int once = 0;
    while (busy && n < 100) begin
      cycle();
      n++;
    end
    check({tag, "_busy_cycles"}, clr_idx, 32'd32);
    check({tag, "_clear_writes"}, clr_ok, 32'd32);
    foreach (wr_seen[i]) if (wr_seen[i] == 1) once++;
    check({tag, "_each_addr_once"}, once, 32'd32);
    foreach (ref_mem[i]) ref_mem[i] = CLR;
  endtask

  initial begin
    int t;
    int extra;
    int rsp_base;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rsp_ready = 1'b1;
    start_clear_tracking();
    rst_b = 1'b1;
    finish_clear("clear");

    // Reads after clear
    chk_lat = 1'b1;
    issue(1'b0, 0, 8'h00, 8'h00, t);
    issue(1'b0, 17, 8'h00, 8'h00, t);
    issue(1'b0, 31, 8'h00, 8'h00, t);
    drain();
    check("clear_read_last", 32'(last_rsp), 32'(CLR));

    // Masked write then immediate read of the same address
    issue(1'b1, 5, 8'hFF, 8'h0F, t);
    issue(1'b0, 5, 8'h00, 8'h00, t);
    drain();
    check("masked_write", 32'(last_rsp), 32'((CLR & 8'hF0) | 8'h0F));

    // Distinct contents, then back-to-back reads
    for (int i = 0; i < 8; i++) issue(1'b1, i, 8'(i * 8'h11) ^ 8'h3C, 8'hFF, t);
    rsp_base = n_rsp;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, i, 8'h00, 8'h00, t);
      if (i > 0) check("b2b_tries", t, 32'd1);
    end
    drain();
    check("b2b_count", n_rsp - rsp_base, 32'd8);
    chk_lat = 1'b0;

    // Backpressure: third read must wait for a pop
    rsp_ready = 1'b0;
    re3 = 0;
    rsp_base = n_rsp;
    issue(1'b0, 1, 8'h00, 8'h00, t);
    issue(1'b0, 2, 8'h00, 8'h00, t);
    req_addr = AW'(3);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      extra += int'(acc_flag);
    end
    check("bp_no_accept", extra, 32'd0);
    check("bp_req_ready", 32'(req_ready), 32'd0);
    check("bp_no_sram_read", re3, 32'd0);
    check("bp_queued", exp_q.size(), 32'd2);
    check("bp_head_valid", 32'(rsp_valid), 32'd1);
    check("bp_head_data", 32'(rsp_rdata), 32'(8'(1 * 8'h11) ^ 8'h3C));
    rsp_ready = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc_flag && n < 20);
    check("bp_third_accept", 32'(acc_flag), 32'd1);
    drain();
    check("bp_count", n_rsp - rsp_base, 32'd3);
    check("bp_sram_read3", re3, 32'd1);

    // Random mix
    overlap = 0;
    for (int k = 0; k < 10000; k++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, DEPTH - 1));
      req_wdata = 8'($urandom);
      req_wmask = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rsp_ready = 1'b1;
    drain();
    check("no_re_we_overlap", overlap, 32'd0);

    // Reset mid-operation with queued responses, then mid-clear
    rsp_ready = 1'b0;
    issue(1'b0, 4, 8'h00, 8'h00, t);
    issue(1'b0, 6, 8'h00, 8'h00, t);
    req_valid = 1'b0;
    cycle();
    cycle();
    check("pre_reset_held", 32'(rsp_valid), 32'd1);
    rst_b = 1'b0;
    #1;
    check_reset_outputs("reset_run");
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    start_clear_tracking();
    rst_b = 1'b1;
    n = 0;
    while (clr_idx < 10 && n < 50) begin
      cycle();
      n++;
    end
    check("midclear_progress", clr_ok, 32'd10);
    rst_b = 1'b0;
    #1;
    check_reset_outputs("reset_clear");
    repeat (2) @(posedge clk);
    #1;
    start_clear_tracking();
    rst_b = 1'b1;
    finish_clear("reclear");
    chk_lat = 1'b1;
    issue(1'b0, 4, 8'h00, 8'h00, t);
    drain();
    check("reclear_read", 32'(last_rsp), 32'(CLR));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
